// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: shared types and constants for the bit-serial adder/subtractor.
// Contents: FSM state encoding (IDLE/RUN/DONE) and the add/subtract mode constants.
// Used by serial_addsub and full_addsub_cell.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_addsub_cell.sv
// full_addsub_cell: combinational 1-bit full adder / full subtractor.
// Ports: x, y operand bits; cin carry-in (add) or borrow-in (sub); mode selects add/sub;
//        s sum/difference bit; cout carry-out (add) or borrow-out (sub).
module full_addsub_cell
    import serial_addsub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic cin,
    input  logic mode,
    output logic s,
    output logic cout
);

    always_comb begin
        // Sum and difference bits share the same parity equation.
        s = x ^ y ^ cin;
        if (mode == MODE_SUB) begin
            cout = (~x & y) | (~(x ^ y) & cin);
        end else begin
            cout = (x & y) | (cin & (x ^ y));
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// Ports: clk, rst (async active-high); start/mode/a/b request; busy, done (1-cycle pulse),
//        result, cout (carry or borrow), ovf (signed overflow when SERIAL_ADDSUB_OVF_EN is defined, else 0).
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 result bits produced so far; the final bit joins them on the last cycle.
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic             mode_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt;
    logic             cell_s;
    logic             cell_c;
    logic             accept;
    logic             last_bit;

    full_addsub_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .cin  (carry_r),
        .mode (mode_r),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    assign res_next = {cell_s, res_sr};

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state and status outputs
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // A start seen in DONE launches the next operation without an IDLE gap.
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Serial datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            mode_r  <= MODE_ADD;
            carry_r <= 1'b0;
            cnt     <= '0;
            result  <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            mode_r  <= mode;
            carry_r <= 1'b0;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            res_sr  <= res_next[WIDTH-1:1];
            carry_r <= cell_c;
            cnt     <= cnt + CNT_W'(1);
            // Visible outputs change only when the final bit is produced.
            if (last_bit) begin
                result <= res_next;
                cout   <= cell_c;
            end
        end
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic a_msb;
    logic b_msb;
    logic ovf_calc;

    // cell_s is the result MSB during the last RUN cycle.
    always_comb begin
        if (mode_r == MODE_SUB) begin
            ovf_calc = (a_msb != b_msb) && (cell_s != a_msb);
        end else begin
            ovf_calc = (a_msb == b_msb) && (cell_s != a_msb);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == RUN && last_bit) begin
            ovf <= ovf_calc;
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; successor to the 1-bit full subtractor.
- Takes two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, through a single full add/sub cell.
- Reports result, carry/borrow and done; used where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- mode  input  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  sum/difference; held until next accepted start.
- cout  output  1  add: carry out; sub: borrow out (1 means a < b unsigned).
- ovf  output  1  signed overflow (see Optional Feature).

Behaviour:
- Reset (async, any state, including mid-RUN): state=IDLE; busy=0, done=0, result=0, cout=0, ovf=0; shift registers and counter cleared; in-flight operation discarded.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 -> latch a, b, mode; carry/borrow reg=0; counter=0; go RUN.
  - RUN: each edge computes bit k from a_sr[0], b_sr[0] and the carry/borrow reg, then shifts all registers right.
    - Result bit shifts in at the MSB.
    - Counter increments; when counter==WIDTH-1 go DONE.
  - DONE (exactly one cycle): done=1, busy=0. start=1 here is accepted like IDLE (back-to-back, go RUN); otherwise go IDLE.
- Cell equations:
  - add: s=a^b^c; c'=(a&b)|(c&(a^b)).
  - sub: d=a^b^bin; bout=(~a&b)|(~(a^b)&bin).
- Latency: start sampled at edge E0; busy=1 after E0 through E_WIDTH; done=1 and result/cout valid in the cycle after E_WIDTH. Total: WIDTH+1 edges.
- Output holding: result, cout and ovf are updated only on RUN->DONE; they hold across IDLE and the next RUN.
- start while in RUN: ignored; a/b/mode changes during RUN have no effect.
- Width rules: result is modulo 2^WIDTH. cout is bit WIDTH of the unsigned add, or the final borrow of the unsigned subtract.

Optional Feature:
- Macro SERIAL_ADDSUB_OVF_EN.
- Defined:
  - ovf = signed two's-complement overflow, updated with result.
  - add: a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - sub: a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - Computed in the last RUN cycle from the latched MSBs.
- Not defined: ovf tied to 0; no MSB capture logic.
- Port list is identical in both builds.

Decomposition:
- Package serial_addsub_pkg:
  - state enum (IDLE, RUN, DONE), 2 bits;
  - mode constants MODE_ADD=0, MODE_SUB=1.
- Sub-module full_addsub_cell: combinational, 1-bit.
  - Inputs: x, y, cin, mode. Outputs: s, cout.
  - Implements both equations above and is instanced once.

Test Plan:
- Reset then idle, WIDTH=8: all outputs 0.
  - mode=0, a=0x35, b=0x4A, start 1 cycle -> busy 8 cycles, then done pulse 1 cycle.
  - result=0x7F, cout=0, ovf=0.
- mode=1, a=0x05, b=0x09 -> result=0xFC, cout=1 (borrow).
  - With SERIAL_ADDSUB_OVF_EN: ovf=0.
- Overflow (macro on):
  - add a=0x7F, b=0x01 -> result=0x80, cout=0, ovf=1.
  - sub a=0x80, b=0x01 -> result=0x7F, cout=0, ovf=1.
  - Macro off: ovf=0 in both cases.
- Back-to-back and ignored start:
  - start held high across DONE -> second op (0xFF+0x01) begins with no IDLE cycle.
  - Result 0x00, cout=1.
  - start pulses during RUN are ignored; operands changed mid-RUN do not affect result.
- Reset mid-op: assert rst at 4th RUN cycle of a=0xAA-b=0x55 -> outputs 0 immediately (async).
  - No done pulse; a fresh start afterwards gives result=0x55, cout=0.
- Exhaustive sweep WIDTH=4, both modes, all 256 operand pairs: result/cout match the reference model.
  - The sweep also covers the 1-bit full-subtractor truth table.
